// File: rtl/serial_subtractor.sv
// Bit-serial subtractor computing a - b - bin, one bit per clock, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             br_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic             d_bit_d;
  logic             br_d;
  logic [WIDTH:0]   res_ext_d;
  logic [WIDTH-1:0] res_d;

  // One full-subtractor step on the current LSBs; the new bit enters the result at the MSB end.
  always_comb begin
    d_bit_d   = a_q[0] ^ b_q[0] ^ br_q;
    br_d      = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    res_ext_d = {d_bit_d, res_q};
    res_d     = res_ext_d[WIDTH:1];
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_q;
  logic b_msb_q;
  logic ovf_q;

  // Operand sign bits are kept aside since the shift registers lose them during RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (state_q == ST_IDLE && in_valid && in_ready_q) begin
      a_msb_q <= a[WIDTH-1];
      b_msb_q <= b[WIDTH-1];
    end else if (state_q == ST_RUN && cnt_q == LAST_BIT) begin
      ovf_q <= (a_msb_q ^ b_msb_q) & (d_bit_d ^ a_msb_q);
    end else begin
      ovf_q <= ovf_q;
    end
  end

  assign ovf = ovf_q;
`endif

  // Control FSM and datapath registers; result outputs load only on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      br_q        <= 1'b0;
      cnt_q       <= '0;
      res_q       <= '0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= b;
            br_q       <= bin;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ST_RUN;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          a_q   <= a_q >> 1'b1;
          b_q   <= b_q >> 1'b1;
          br_q  <= br_d;
          res_q <= res_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_BIT) begin
            diff_q      <= res_d;
            bout_q      <= br_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            state_q <= ST_DONE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against an arithmetic reference model.
// Define SERIAL_SUB_OVF_EN to also exercise the overflow output.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int errors = 0;
  int checks = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bout     (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full operation; hold = cycles out_ready stays low after out_valid rises.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                        input int hold);
    int          full;
    int          sfull;
    int          n;
    logic [W-1:0] exp_diff;
    logic        exp_bout;
    logic        exp_ovf;
    full     = int'(av) - int'(bv) - int'(bi);
    exp_diff = full[W-1:0];
    exp_bout = (full < 0);
    sfull    = (av >= 8'd128 ? int'(av) - 256 : int'(av))
             - (bv >= 8'd128 ? int'(bv) - 256 : int'(bv)) - int'(bi);
    exp_ovf  = (sfull > 127) || (sfull < -128);

    @(negedge clk);
    check_eq("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    a         = av;
    b         = bv;
    bin       = bi;
    out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    n        = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check_eq("latency", n, W);
    check_eq("in_ready_busy", {31'd0, in_ready}, 32'd0);
    check_eq("diff", {24'd0, diff}, {24'd0, exp_diff});
    check_eq("bout", {31'd0, bout}, {31'd0, exp_bout});
`ifdef SERIAL_SUB_OVF_EN
    check_eq("ovf", {31'd0, ovf}, {31'd0, exp_ovf});
`endif
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a        = 8'h01;
      b        = 8'h01;
      @(posedge clk);
      @(negedge clk);
      check_eq("bp_valid", {31'd0, out_valid}, 32'd1);
      check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check_eq("bp_diff", {24'd0, diff}, {24'd0, exp_diff});
      check_eq("bp_bout", {31'd0, bout}, {31'd0, exp_bout});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("valid_drop", {31'd0, out_valid}, 32'd0);
    check_eq("in_ready_back", {31'd0, in_ready}, 32'd1);
    check_eq("diff_held", {24'd0, diff}, {24'd0, exp_diff});
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    #12;
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_diff", {24'd0, diff}, 32'd0);
    check_eq("rst_bout", {31'd0, bout}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check_eq("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h35, 8'h12, 1'b0, 0);
    run_op(8'h00, 8'h01, 1'b0, 0);
    run_op(8'hFF, 8'hFF, 1'b1, 0);
    run_op(8'h80, 8'h01, 1'b0, 0);
    run_op(8'h10, 8'h01, 1'b0, 0);
    run_op(8'h35, 8'h12, 1'b0, 5);
    run_op(8'hA7, 8'h3C, 1'b1, 0);

    // Reset in the middle of RUN, after three bits have been processed.
    @(negedge clk);
    in_valid  = 1'b1;
    a         = 8'hC3;
    b         = 8'h5A;
    bin       = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mid_rst_diff", {24'd0, diff}, 32'd0);
    check_eq("mid_rst_bout", {31'd0, bout}, 32'd0);
    check_eq("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_eq("no_stale_valid", {31'd0, out_valid}, 32'd0);
    end
    run_op(8'h35, 8'h12, 1'b0, 0);

    for (int i = 0; i < 30; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

- Bit-serial subtractor: computes `a - b - bin` over `WIDTH` clock cycles, one bit per cycle, LSB first, through a single-bit borrow chain.
- Complements the team's ripple full-adder datapath.
- Intended for area-constrained arithmetic paths where a multi-cycle result is acceptable.
- Operands enter on a valid/ready handshake. Results leave on a second valid/ready handshake with backpressure.

## Interface

- `WIDTH`, default 8: operand and result width in bits; legal range ≥ 1.

Ports:

- `clk`  input  1  — single clock, rising edge.
- `rst_n`  input  1  — reset, asynchronous, active-low.
- `in_valid`  input  1  — operands present.
- `in_ready`  output  1  — block can accept operands.
- `a`  input  `WIDTH`  — minuend.
- `b`  input  `WIDTH`  — subtrahend.
- `bin`  input  1  — borrow in.
- `out_valid`  output  1  — result present.
- `out_ready`  input  1  — consumer accepts result.
- `diff`  output  `WIDTH`  — difference.
- `bout`  output  1  — borrow out.
- `ovf`  output  1  — signed overflow; exists only with `SERIAL_SUB_OVF_EN`.

## Operation

States:

- **IDLE**
  - `in_ready`=1.
  - On `in_valid && in_ready` at a rising edge: capture `a`, `b`, `bin` into shift registers; clear the bit counter; go to RUN.
- **RUN**
  - At each edge, process bit i:
    - `d_i = a_i ^ b_i ^ br`
    - `br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)`
  - `d_i` shifts into the result register; the counter increments.
  - After bit `WIDTH-1` is processed, go to DONE. `diff` and `bout` are registered on that same edge.
- **DONE**
  - `out_valid`=1; `diff`, `bout` (and `ovf`) held stable.
  - On `out_valid && out_ready` at an edge: go to IDLE and clear `out_valid`.

Rules:

- `in_ready`=0 in RUN and DONE. `in_valid` and operand inputs are ignored there; no queuing.
- Arithmetic:
  - `diff = (a - b - bin) mod 2^WIDTH`.
  - `bout`=1 iff unsigned `a < b + bin`.
- `bout` equals the final `br`.
- Result outputs change only on entry to DONE. Outside DONE they hold the last result; the consumer qualifies them with `out_valid`.
- Reset mid-operation:
  - Async assert immediately drops to IDLE and abandons the operation; no `out_valid` is produced.
  - Outputs take reset values.
- `WIDTH`=1: RUN lasts exactly one cycle.

## Timing

- Reset values:
  - `in_ready`=1 (state IDLE).
  - `out_valid`=0, `diff`=0, `bout`=0, `ovf`=0.
- Latency:
  - Input handshake at edge E0.
  - RUN occupies edges E1..E`WIDTH`.
  - `out_valid` goes high immediately after edge E`WIDTH`.
- Result hold: when `out_ready` is already high on entering DONE, the result is held for exactly one cycle. IDLE is re-entered at edge E`WIDTH+1`.
- Throughput: in the best case, one operation per `WIDTH+2` cycles (IDLE accept cycle + `WIDTH` RUN + 1 DONE).
- Backpressure: DONE lasts until `out_ready` is sampled high. Outputs are bit-stable throughout.
- `in_ready` is a registered state decode. It changes only on clock edges or asynchronous reset.

## Configuration

- Macro: `SERIAL_SUB_OVF_EN`.
- **Defined:**
  - Port `ovf` exists.
  - `ovf = (a[MSB] ^ b[MSB]) & (diff[MSB] ^ a[MSB])`, evaluated on the captured operands. Registered on entry to DONE, held with `diff`, reset to 0.
  - Two's-complement overflow interpretation.
  - `bin` is excluded from the overflow formula.
- **Undefined:**
  - Port `ovf` and its logic are absent.
  - All other behaviour is identical.

## Test plan

1. `WIDTH`=8, a=0x35, b=0x12, bin=0, `out_ready`=1. Required:
   - `diff`=0x23, `bout`=0.
   - `out_valid` rises 8 cycles after accept and lasts 1 cycle.
   - `in_ready` returns to 1 one cycle later.
2. a=0x00, b=0x01, bin=0. Required: `diff`=0xFF, `bout`=1.
3. a=0xFF, b=0xFF, bin=1. Required: `diff`=0xFF, `bout`=1.
4. a=0x80, b=0x01, bin=0. Required:
   - `diff`=0x7F, `bout`=0.
   - `ovf`=1 with `SERIAL_SUB_OVF_EN`; port absent without it.
   - Also a=0x10, b=0x01: `ovf`=0.
5. Backpressure, a=0x35, b=0x12 (`diff`=0x23):
   - Hold `out_ready`=0 for 5 cycles after `out_valid` rises. Drive `in_valid` with a=0x01, b=0x01 throughout.
   - Required: `diff` stays 0x23, `in_ready`=0, new operands ignored.
   - After the `out_ready` pulse, the next accepted op returns its own correct result.
6. Assert `rst_n`=0 mid-RUN after 3 bits processed. Required:
   - Immediately `out_valid`=0, `diff`=0, `bout`=0, `in_ready`=1.
   - No stale `out_valid` after release.
   - A subsequent a=0x35, b=0x12 yields 0x23.
